// File: rtl/rv_serdes_pkg.sv
// rv_serdes_pkg: shared state types and counter sizing for rv_serdes_interface
package rv_serdes_pkg;

    typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;
    typedef enum logic {WR_COLLECT, WR_UPDATE} wr_state_t;

    function automatic int cnt_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_beat_counter.sv
// rv_beat_counter: beat index within a word, wrapping to 0 after the last beat
module rv_beat_counter
    import rv_serdes_pkg::*;
#(
    parameter int NUM_BEATS = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            inc_i,
    output logic [cnt_width(NUM_BEATS)-1:0] count_o,
    output logic                            last_o
);

    localparam int CW = cnt_width(NUM_BEATS);

    logic [CW-1:0] count_q, count_d;

    assign count_o = count_q;
    assign last_o  = count_q == CW'(NUM_BEATS - 1);

    // clear wins over increment; increment on the last beat wraps
    always_comb begin
        count_d = clear_i ? '0 : (inc_i ? (last_o ? '0 : count_q + 1'b1) : count_q);
    end

    // counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/rv_serdes_interface.sv
// rv_serdes_interface: register <-> beat-stream width converter; RV_SERDES_CHANGE_QUEUE_EN queues CHANGE_I seen mid-read
module rv_serdes_interface
    import rv_serdes_pkg::*;
#(
    parameter int BEAT_WIDTH = 8,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  READ_ENABLE_I,
    input  logic                  READ_READY_I,
    output logic                  READ_VALID_O,
    output logic [BEAT_WIDTH-1:0] READ_DATA_O,
    output logic                  READ_LAST_O,
    input  logic                  WRITE_ENABLE_I,
    output logic                  WRITE_READY_O,
    input  logic                  WRITE_VALID_I,
    input  logic [BEAT_WIDTH-1:0] WRITE_DATA_I,
    output logic                  UPDATE_O,
    output logic [REG_WIDTH-1:0]  DATA_O,
    input  logic                  CHANGE_I,
    input  logic [REG_WIDTH-1:0]  DATA_I
);

    localparam int NUM_BEATS = REG_WIDTH / BEAT_WIDTH;
    localparam int CW        = cnt_width(NUM_BEATS);

    if (REG_WIDTH % BEAT_WIDTH != 0) begin : g_width_chk
        $error("REG_WIDTH must be a multiple of BEAT_WIDTH");
    end

    rd_state_t            rd_state_q, rd_state_d;
    wr_state_t            wr_state_q, wr_state_d;
    logic [REG_WIDTH-1:0] shadow_q, shadow_d;
    logic [REG_WIDTH-1:0] asm_q, asm_d;
    logic [REG_WIDTH-1:0] data_q, data_d;
    logic                 rd_clear, rd_inc, rd_last, wr_acc, wr_last;
    logic [CW-1:0]        rd_cnt, wr_cnt;
`ifdef RV_SERDES_CHANGE_QUEUE_EN
    logic                 pend_q, pend_d;
`endif

    assign DATA_O = data_q;

    rv_beat_counter #(.NUM_BEATS(NUM_BEATS)) u_rd_cnt (
        .clk_i(CLK_I), .rst_i(RST_I), .clear_i(rd_clear), .inc_i(rd_inc),
        .count_o(rd_cnt), .last_o(rd_last)
    );

    rv_beat_counter #(.NUM_BEATS(NUM_BEATS)) u_wr_cnt (
        .clk_i(CLK_I), .rst_i(RST_I), .clear_i(1'b0), .inc_i(wr_acc),
        .count_o(wr_cnt), .last_o(wr_last)
    );

    // read FSM: snapshot DATA_I on a trigger, then stream it LSB-first
    always_comb begin
        rd_state_d   = rd_state_q;
        shadow_d     = shadow_q;
        rd_clear     = 1'b0;
        rd_inc       = 1'b0;
        READ_VALID_O = 1'b0;
        READ_DATA_O  = '0;
        READ_LAST_O  = 1'b0;
`ifdef RV_SERDES_CHANGE_QUEUE_EN
        pend_d       = pend_q;
`endif
        if (rd_state_q == RD_IDLE) begin
            if ((READ_ENABLE_I && READ_READY_I) || CHANGE_I) begin
                shadow_d   = DATA_I;
                rd_clear   = 1'b1;
                rd_state_d = RD_SEND;
            end
        end else begin
            READ_VALID_O = 1'b1;
            READ_DATA_O  = shadow_q[int'(rd_cnt) * BEAT_WIDTH +: BEAT_WIDTH];
            READ_LAST_O  = rd_last;
            rd_inc       = READ_READY_I;
`ifdef RV_SERDES_CHANGE_QUEUE_EN
            if (READ_READY_I && rd_last) begin
                if (pend_q || CHANGE_I) begin
                    shadow_d = DATA_I;
                    rd_clear = 1'b1;
                end else begin
                    rd_state_d = RD_IDLE;
                end
                pend_d = 1'b0;
            end else if (CHANGE_I) begin
                pend_d = 1'b1;
            end
`else
            if (READ_READY_I && rd_last) rd_state_d = RD_IDLE;
`endif
        end
    end

    // write FSM: assemble beats, publish the word with a one-cycle update bubble
    always_comb begin
        wr_state_d    = wr_state_q;
        asm_d         = asm_q;
        data_d        = data_q;
        wr_acc        = 1'b0;
        WRITE_READY_O = 1'b0;
        UPDATE_O      = 1'b0;
        if (wr_state_q == WR_COLLECT) begin
            WRITE_READY_O = WRITE_ENABLE_I && !RST_I;
            wr_acc        = WRITE_VALID_I && WRITE_READY_O;
            if (wr_acc) begin
                asm_d[int'(wr_cnt) * BEAT_WIDTH +: BEAT_WIDTH] = WRITE_DATA_I;
                if (wr_last) begin
                    data_d     = asm_d;
                    wr_state_d = WR_UPDATE;
                end
            end
        end else begin
            UPDATE_O   = 1'b1;
            wr_state_d = WR_COLLECT;
        end
    end

    // state and datapath registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_COLLECT;
            shadow_q   <= '0;
            asm_q      <= '0;
            data_q     <= '0;
`ifdef RV_SERDES_CHANGE_QUEUE_EN
            pend_q     <= 1'b0;
`endif
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            shadow_q   <= shadow_d;
            asm_q      <= asm_d;
            data_q     <= data_d;
`ifdef RV_SERDES_CHANGE_QUEUE_EN
            pend_q     <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_rv_serdes_interface.sv
// tb_rv_serdes_interface: scoreboard bench for rv_serdes_interface (32/8 and 8/8 instances)
module tb_rv_serdes_interface;

    logic        clk = 1'b0, rst = 1'b1;
    logic        ren = 1'b0, rrdy = 1'b0, rvalid, rlast;
    logic [7:0]  rdata;
    logic        wen = 1'b0, wready, wval = 1'b0, upd, chg = 1'b0;
    logic [7:0]  wdata = '0;
    logic [31:0] dout, din = '0;

    logic        s_rrdy = 1'b1, s_rvalid, s_rlast, s_wready, s_wval = 1'b0, s_upd, s_chg = 1'b0;
    logic [7:0]  s_rdata, s_wdata = '0, s_dout, s_din = '0;

    int errors = 0;
    int checks = 0;
    logic [8:0]  rd_exp[$];
    logic [31:0] upd_exp[$];
    logic        hold_q = 1'b0;

    rv_serdes_interface #(.BEAT_WIDTH(8), .REG_WIDTH(32)) dut (
        .CLK_I(clk), .RST_I(rst),
        .READ_ENABLE_I(ren), .READ_READY_I(rrdy), .READ_VALID_O(rvalid),
        .READ_DATA_O(rdata), .READ_LAST_O(rlast),
        .WRITE_ENABLE_I(wen), .WRITE_READY_O(wready), .WRITE_VALID_I(wval),
        .WRITE_DATA_I(wdata), .UPDATE_O(upd), .DATA_O(dout),
        .CHANGE_I(chg), .DATA_I(din)
    );

    rv_serdes_interface #(.BEAT_WIDTH(8), .REG_WIDTH(8)) dut_s (
        .CLK_I(clk), .RST_I(rst),
        .READ_ENABLE_I(1'b0), .READ_READY_I(s_rrdy), .READ_VALID_O(s_rvalid),
        .READ_DATA_O(s_rdata), .READ_LAST_O(s_rlast),
        .WRITE_ENABLE_I(1'b1), .WRITE_READY_O(s_wready), .WRITE_VALID_I(s_wval),
        .WRITE_DATA_I(s_wdata), .UPDATE_O(s_upd), .DATA_O(s_dout),
        .CHANGE_I(s_chg), .DATA_I(s_din)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) rd_exp.push_back({i == 3, w[i*8 +: 8]});
    endtask

    task automatic write_word(input logic [31:0] w);
        upd_exp.push_back(w);
        wen  = 1'b1;
        wval = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wdata = w[i*8 +: 8];
            tick;
        end
        wval = 1'b0;
        tick;
    endtask

    // monitor: every read handshake and every update pulse is checked against the queues
    always @(negedge clk) begin
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) chk("rd_valid_hold", {31'd0, rvalid}, 32'd1);
            hold_q = rvalid && !rrdy;
            if (rvalid && rrdy) begin
                if (rd_exp.size() == 0) chk("rd_unexpected_valid", {31'd0, rvalid}, 32'd0);
                else begin
                    logic [8:0] e;
                    e = rd_exp.pop_front();
                    chk("rd_beat_data", {24'd0, rdata}, {24'd0, e[7:0]});
                    chk("rd_beat_last", {31'd0, rlast}, {31'd0, e[8]});
                end
            end
            if (upd) begin
                if (upd_exp.size() == 0) chk("unexpected_update", {31'd0, upd}, 32'd0);
                else chk("update_data", dout, upd_exp.pop_front());
                chk("update_wready", {31'd0, wready}, 32'd0);
            end
        end
    end

    initial begin
        wen = 1'b1;
        repeat (2) tick;
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_update", {31'd0, upd}, 32'd0);
        chk("rst_data_o", dout, 32'd0);
        rst = 1'b0;
        tick;
        chk("idle_wready", {31'd0, wready}, 32'd1);
        wen = 1'b0;

        // read via CHANGE_I, consumer always ready
        din  = 32'hA1B2C3D4;
        rrdy = 1'b1;
        push_word(din);
        chg = 1'b1;
        tick;
        chg = 1'b0;
        chk("rd_latency_valid", {31'd0, rvalid}, 32'd1);
        repeat (6) tick;
        chk("rd_idle_after_word", {31'd0, rvalid}, 32'd0);

        // backpressure with DATA_I cleared after capture
        rrdy = 1'b0;
        push_word(32'hA1B2C3D4);
        chg = 1'b1;
        tick;
        chg = 1'b0;
        din = 32'h0;
        for (int i = 0; i < 4; i++) begin
            repeat (2) tick;
            rrdy = 1'b1;
            tick;
            rrdy = 1'b0;
        end
        repeat (2) tick;

        // read request with simultaneous CHANGE_I: one transfer only
        din = 32'h01020304;
        push_word(din);
        ren  = 1'b1;
        rrdy = 1'b1;
        chg  = 1'b1;
        tick;
        ren = 1'b0;
        chg = 1'b0;
        repeat (6) tick;

        // write with enable dropped for two cycles after the second beat
        wen   = 1'b1;
        wval  = 1'b1;
        wdata = 8'h11;
        tick;
        wdata = 8'h22;
        tick;
        wen   = 1'b0;
        wdata = 8'h33;
        repeat (2) tick;
        chk("wr_paused_no_update", {31'd0, upd}, 32'd0);
        wen = 1'b1;
        tick;
        wdata = 8'h44;
        upd_exp.push_back(32'h44332211);
        tick;
        wval = 1'b0;
        chk("wr_update_pulse", {31'd0, upd}, 32'd1);
        chk("wr_update_wready", {31'd0, wready}, 32'd0);
        tick;
        chk("wr_update_one_cycle", {31'd0, upd}, 32'd0);
        chk("wr_data_stable", dout, 32'h44332211);

        // CHANGE_I while a word is streaming
        din = 32'hA1B2C3D4;
        push_word(din);
        chg = 1'b1;
        tick;
        din = 32'h55667788;
`ifdef RV_SERDES_CHANGE_QUEUE_EN
        push_word(din);
`endif
        tick;
        chg = 1'b0;
        repeat (3) tick;
`ifdef RV_SERDES_CHANGE_QUEUE_EN
        chk("rd_queued_change_valid", {31'd0, rvalid}, 32'd1);
`else
        chk("rd_ignored_change_valid", {31'd0, rvalid}, 32'd0);
`endif
        repeat (6) tick;

        // asynchronous reset mid-read and mid-write
        rrdy  = 1'b0;
        din   = 32'hCAFEF00D;
        chg   = 1'b1;
        wval  = 1'b1;
        wdata = 8'h99;
        tick;
        chg   = 1'b0;
        wdata = 8'h88;
        tick;
        wval = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("arst_rdata", {24'd0, rdata}, 32'd0);
        chk("arst_wready", {31'd0, wready}, 32'd0);
        chk("arst_update", {31'd0, upd}, 32'd0);
        chk("arst_data_o", dout, 32'd0);
        tick;
        rst = 1'b0;
        tick;
        write_word(32'hDEADBEEF);
        chk("post_rst_data_o", dout, 32'hDEADBEEF);
        rrdy = 1'b1;
        repeat (2) tick;
        chk("post_rst_rd_idle", {31'd0, rvalid}, 32'd0);

        // single-beat instance
        s_din = 8'h5A;
        s_chg = 1'b1;
        tick;
        s_chg = 1'b0;
        chk("s_rd_valid", {31'd0, s_rvalid}, 32'd1);
        chk("s_rd_data", {24'd0, s_rdata}, 32'h5A);
        chk("s_rd_last", {31'd0, s_rlast}, 32'd1);
        tick;
        chk("s_rd_idle", {31'd0, s_rvalid}, 32'd0);
        s_wval  = 1'b1;
        s_wdata = 8'h77;
        tick;
        s_wdata = 8'h88;
        chk("s_wr_update1", {31'd0, s_upd}, 32'd1);
        chk("s_wr_data1", {24'd0, s_dout}, 32'h77);
        chk("s_wr_wready_upd", {31'd0, s_wready}, 32'd0);
        repeat (2) tick;
        s_wval = 1'b0;
        chk("s_wr_update2", {31'd0, s_upd}, 32'd1);
        chk("s_wr_data2", {24'd0, s_dout}, 32'h88);

        repeat (4) tick;
        chk("rd_queue_drained", rd_exp.size(), 32'd0);
        chk("upd_queue_drained", upd_exp.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
